// File: rtl/datapath_pkg.sv
// datapath_pkg: constants shared by the datapath component library.
//   CNT_WRAP / CNT_SAT : counter boundary mode (SATURATE parameter values)
//   DIR_DOWN / DIR_UP  : counter direction (value of the up input)
package datapath_pkg;

  localparam int unsigned CNT_WRAP = 32'd0;
  localparam int unsigned CNT_SAT  = 32'd1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage : datapath_pkg

// File: rtl/clk_en_prescaler.sv
// clk_en_prescaler: divides an enable into a one-cycle step strobe.
// The phase counter advances on every enabled edge and wraps modulo DIV;
// step is high during the cycle whose edge completes a full DIV period.
//   clk      in  : rising-edge clock
//   rst      in  : asynchronous active-high reset (phase <= 0)
//   en       in  : advance the phase on this edge
//   sync_clr in  : synchronous phase clear, overrides en and masks step
//   step     out : combinational strobe, 1 when this edge is a step edge
module clk_en_prescaler #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  // A DIV of 1 still gets a 1-bit phase register that simply stays at 0.
  localparam int unsigned    PW   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [PW-1:0]  LAST = PW'(DIV - 32'd1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          last_s;

  assign last_s = (phase_q == LAST);
  assign step   = en && last_s && !sync_clr;

  // Next phase: clear wins, then modulo-DIV advance while enabled.
  always_comb begin
    phase_d = phase_q;
    if (sync_clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = last_s ? '0 : (phase_q + 1'b1);
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule : clk_en_prescaler

// File: rtl/prog_counter.sv
// prog_counter: parametrised up/down counter with load, programmable limit,
// wrap or saturate at the boundary, prescaled stepping, a registered
// boundary-event pulse and a sticky overflow flag.
//   clk, rst        : clock, asynchronous active-high reset
//   in, ld          : load value (clamped to limit), synchronous load
//   cnt, up         : count enable, direction (DIR_UP / DIR_DOWN)
//   clr             : synchronous clear to 0 (highest priority)
//   limit           : upper bound, count range is 0..limit
//   ovf_clr         : clears ovf (a same-edge boundary event wins)
//   count           : current count
//   tcount          : combinational terminal flag
//   tc_pulse        : one-cycle pulse after each boundary event
//   ovf             : sticky boundary-event flag
module prog_counter
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             ld,
  input  logic             cnt,
  input  logic             up,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tcount,
  output logic             tc_pulse,
  output logic             ovf
);

  localparam bit SAT_MODE = (SATURATE == CNT_SAT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_pulse_q;
  logic             ovf_q;
  logic             ovf_d;
  logic             step_s;
  logic             evt_s;

  // Clear or load restarts the prescaler phase and suppresses the step.
  clk_en_prescaler #(
    .DIV (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt),
    .sync_clr (clr | ld),
    .step     (step_s)
  );

  // Next count and boundary event: clr > ld > step.
  always_comb begin
    count_d = count_q;
    evt_s   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (ld) begin
      count_d = (in > limit) ? limit : in;
    end else if (step_s) begin
      if (up == DIR_UP) begin
        // >= also catches a count left above a lowered limit.
        if (count_q >= limit) begin
          evt_s   = 1'b1;
          count_d = SAT_MODE ? limit : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          evt_s   = 1'b1;
          count_d = SAT_MODE ? '0 : limit;
        end else if (count_q > limit) begin
          count_d = limit;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Sticky overflow: a boundary event outranks ovf_clr.
  always_comb begin
    ovf_d = ovf_q;
    if (evt_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      tc_pulse_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_pulse_q <= evt_s;
      ovf_q      <= ovf_d;
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_pulse_q;
  assign ovf      = ovf_q;
  assign tcount   = (up == DIR_UP) ? (count_q == limit) : (count_q == '0);

endmodule : prog_counter
